sevenseg_595_capture: RTL and testbench

//  Receive end of the 2x74HC595 display link: samples SCLK/DATA/LATCH as driven to the chained 595s,

---
 rtl/sevenseg_pkg.sv | 26 ++
 rtl/sevenseg_595_capture_if.sv | 9 +
 rtl/sevenseg_595_capture_decode.sv | 25 ++
 rtl/sevenseg_595_capture.sv | 97 +++++++++
 tb/tb_sevenseg_595_capture.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// Shared 7-segment constants and helpers for the 595 display link (transmit and receive sides).
package sevenseg_pkg;

    localparam int WORD_BITS = 16;

    // gfedcba, active-high
    localparam logic [6:0] SEG_PAT_0 = 7'h3F;
    localparam logic [6:0] SEG_PAT_1 = 7'h06;
    localparam logic [6:0] SEG_PAT_2 = 7'h5B;
    localparam logic [6:0] SEG_PAT_3 = 7'h4F;
    localparam logic [6:0] SEG_PAT_4 = 7'h66;
    localparam logic [6:0] SEG_PAT_5 = 7'h6D;
    localparam logic [6:0] SEG_PAT_6 = 7'h7D;
    localparam logic [6:0] SEG_PAT_7 = 7'h07;
    localparam logic [6:0] SEG_PAT_8 = 7'h7F;
    localparam logic [6:0] SEG_PAT_9 = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK   = 4'd10;
    localparam logic [3:0] CODE_UNKNOWN = 4'd15;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/sevenseg_595_capture_if.sv
// Serial link as seen at the chained 595 inputs: shift clock, data, latch.
interface sevenseg_595_capture_if;
    logic sclk;
    logic data;
    logic latch;

    modport master (output sclk, data, latch);
    modport slave  (input  sclk, data, latch);
endinterface

// File: rtl/sevenseg_595_capture_decode.sv
// Active-high gfedcba pattern to digit code; anything unrecognised maps to CODE_UNKNOWN.
module seg7_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] code_o
);
    always_comb begin
        code_o = CODE_UNKNOWN;
        case (seg_i)
            SEG_PAT_0: code_o = 4'd0;
            SEG_PAT_1: code_o = 4'd1;
            SEG_PAT_2: code_o = 4'd2;
            SEG_PAT_3: code_o = 4'd3;
            SEG_PAT_4: code_o = 4'd4;
            SEG_PAT_5: code_o = 4'd5;
            SEG_PAT_6: code_o = 4'd6;
            SEG_PAT_7: code_o = 4'd7;
            SEG_PAT_8: code_o = 4'd8;
            SEG_PAT_9: code_o = 4'd9;
            SEG_BLANK: code_o = CODE_BLANK;
            default:   code_o = CODE_UNKNOWN;
        endcase
    end
endmodule

// File: rtl/sevenseg_595_capture.sv
// Receive side of the 2x595 display link: resync, rebuild 16-bit words, check them and
// maintain a 4-digit + colon framebuffer with word/frame strobes and a sticky error.
module sevenseg_595_capture
    import sevenseg_pkg::*;
#(
    parameter int NUM_ICS        = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    sevenseg_595_capture_if.slave   link,
    output logic                    word_valid_o,
    output logic [WORD_BITS-1:0]    word_o,
    output logic [15:0]             digits_o,
    output logic                    colon_o,
    output logic                    frame_valid_o,
    output logic                    err_o
);
    localparam logic [4:0] WB = 5'(8 * NUM_ICS);

    logic [2:0]           sclk_q, latch_q;
    logic [1:0]           data_q;
    logic [WORD_BITS-1:0] sr_q, sr_d, word_q;
    logic [4:0]           cnt_q, cnt_d;
    logic [3:0]           seen_q, seen_set;
    logic [15:0]          digits_q, digits_d;
    logic                 colon_q, err_q, word_valid_q, frame_valid_q;
    logic                 sclk_rise, latch_rise, accept, frame_done, dp_lit;
    logic [6:0]           seg_lit;
    logic [3:0]           code;

    assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
    assign latch_rise = latch_q[1] & ~latch_q[2];

    // Shift resolves before the check, so a latch coincident with the last sclk edge sees that bit.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (sclk_rise) begin
            sr_d = {sr_q[WORD_BITS-2:0], data_q[1]};
            if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
        end
    end

    assign accept     = latch_rise && (cnt_d == WB) && is_onehot4(sr_d[3:0]);
    assign seg_lit    = SEG_ACTIVE_LOW ? ~sr_d[14:8] : sr_d[14:8];
    assign dp_lit     = SEG_ACTIVE_LOW ? ~sr_d[15]   : sr_d[15];
    assign seen_set   = seen_q | sr_d[3:0];
    assign frame_done = accept && (seen_set == 4'hF);

    seg7_pattern_decode u_dec (.seg_i(seg_lit), .code_o(code));

    always_comb begin
        digits_d = digits_q;
        for (int n = 0; n < 4; n++)
            if (sr_d[n]) digits_d[n*4 +: 4] = code;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sclk_q        <= '0;
            latch_q       <= '0;
            data_q        <= '0;
            sr_q          <= '0;
            cnt_q         <= '0;
            seen_q        <= '0;
            word_q        <= '0;
            digits_q      <= 16'hAAAA;
            colon_q       <= 1'b0;
            err_q         <= 1'b0;
            word_valid_q  <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            sclk_q        <= {sclk_q[1:0], link.sclk};
            latch_q       <= {latch_q[1:0], link.latch};
            data_q        <= {data_q[0], link.data};
            sr_q          <= sr_d;
            cnt_q         <= latch_rise ? 5'd0 : cnt_d;
            word_valid_q  <= accept;
            frame_valid_q <= frame_done;
            if (accept) begin
                word_q   <= sr_d;
                digits_q <= digits_d;
                seen_q   <= frame_done ? 4'h0 : seen_set;
                if (sr_d[1]) colon_q <= dp_lit;
            end
            if (latch_rise && !accept) err_q <= 1'b1;
        end
    end

    assign word_valid_o  = word_valid_q;
    assign word_o        = word_q;
    assign digits_o      = digits_q;
    assign colon_o       = colon_q;
    assign frame_valid_o = frame_valid_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_sevenseg_595_capture.sv
// Directed bench for sevenseg_595_capture: table of serial words plus corner-case sequences.
module tb_sevenseg_595_capture;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        word_valid_o, colon_o, frame_valid_o, err_o;
    logic [15:0] word_o, digits_o;

    always #5 clk_i = ~clk_i;

    sevenseg_595_capture_if link();

    sevenseg_595_capture #(.NUM_ICS(2), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .link(link),
        .word_valid_o(word_valid_o), .word_o(word_o), .digits_o(digits_o),
        .colon_o(colon_o), .frame_valid_o(frame_valid_o), .err_o(err_o)
    );

    int errors = 0, checks = 0;
    int wv_cnt = 0, fv_cnt = 0;

    always @(negedge clk_i) begin
        if (word_valid_o === 1'b1) wv_cnt++;
        if (frame_valid_o === 1'b1) fv_cnt++;
    end

    typedef struct {
        logic [15:0] w;
        int          nbits;
        logic [15:0] dig;
        logic        col;
        logic        err;
        int          wv;
        int          fv;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_bit(input logic b);
        link.data = b;
        link.sclk = 1'b0;
        clks(4);
        link.sclk = 1'b1;
        clks(4);
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(i < 16 ? w[i] : 1'b0);
    endtask

    task automatic pulse_latch();
        link.sclk = 1'b0;
        clks(4);
        link.latch = 1'b1;
        clks(4);
        link.latch = 1'b0;
        clks(4);
    endtask

    initial begin
        int wv0, fv0;
        //        word      bits digits    colon err  wv fv
        tbl[0]  = '{16'hF901, 16, 16'hAAA1, 1'b0, 1'b0, 1, 0};
        tbl[1]  = '{16'hA402, 16, 16'hAA21, 1'b0, 1'b0, 1, 0};
        tbl[2]  = '{16'hB004, 16, 16'hA321, 1'b0, 1'b0, 1, 0};
        tbl[3]  = '{16'h9908, 16, 16'h4321, 1'b0, 1'b0, 1, 1};
        tbl[4]  = '{16'h0002, 16, 16'h4381, 1'b1, 1'b0, 1, 0};
        tbl[5]  = '{16'hFF02, 16, 16'h43A1, 1'b0, 1'b0, 1, 0};
        tbl[6]  = '{16'h7F02, 16, 16'h43A1, 1'b1, 1'b0, 1, 0};
        tbl[7]  = '{16'hFE01, 16, 16'h43AF, 1'b1, 1'b0, 1, 0};
        tbl[8]  = '{16'hF901, 15, 16'h43AF, 1'b1, 1'b1, 0, 0};
        tbl[9]  = '{16'hF901, 17, 16'h43AF, 1'b1, 1'b1, 0, 0};
        tbl[10] = '{16'hF903, 16, 16'h43AF, 1'b1, 1'b1, 0, 0};

        link.sclk = 1'b0; link.data = 1'b0; link.latch = 1'b0;
        rst_ni = 1'b0;
        clks(4);
        chk("rst_digits", 32'(digits_o), 32'hAAAA);
        chk("rst_colon", 32'(colon_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_word", 32'(word_o), 32'h0);
        chk("rst_wv", 32'(word_valid_o), 32'h0);
        chk("rst_fv", 32'(frame_valid_o), 32'h0);
        rst_ni = 1'b1;
        clks(2);

        for (int v = 0; v < 11; v++) begin
            wv0 = wv_cnt;
            fv0 = fv_cnt;
            send_bits(tbl[v].w, tbl[v].nbits);
            pulse_latch();
            chk($sformatf("v%0d_digits", v), 32'(digits_o), 32'(tbl[v].dig));
            chk($sformatf("v%0d_colon", v), 32'(colon_o), 32'(tbl[v].col));
            chk($sformatf("v%0d_err", v), 32'(err_o), 32'(tbl[v].err));
            chk($sformatf("v%0d_wv", v), 32'(wv_cnt - wv0), 32'(tbl[v].wv));
            chk($sformatf("v%0d_fv", v), 32'(fv_cnt - fv0), 32'(tbl[v].fv));
            if (tbl[v].wv == 1) chk($sformatf("v%0d_word", v), 32'(word_o), 32'(tbl[v].w));
        end

        // latch rising together with the 16th sclk edge
        wv0 = wv_cnt;
        send_bits(16'h7C80, 15);
        link.data = 1'b1;
        link.sclk = 1'b0;
        clks(4);
        link.sclk = 1'b1;
        link.latch = 1'b1;
        clks(4);
        link.latch = 1'b0;
        link.sclk = 1'b0;
        clks(6);
        chk("simul_wv", 32'(wv_cnt - wv0), 32'd1);
        chk("simul_word", 32'(word_o), 32'hF901);
        chk("simul_digits", 32'(digits_o), 32'h43A1);

        // latch edge to word_valid_o: two sync stages, then one registered cycle
        send_bits(16'hA402, 16);
        link.sclk = 1'b0;
        clks(4);
        link.latch = 1'b1;
        clks(2);
        chk("lat_early", 32'(word_valid_o), 32'h0);
        clks(1);
        chk("lat_pulse", 32'(word_valid_o), 32'h1);
        clks(1);
        chk("lat_one_cycle", 32'(word_valid_o), 32'h0);
        link.latch = 1'b0;
        clks(4);
        chk("lat_digits", 32'(digits_o), 32'h4321);
        chk("lat_colon", 32'(colon_o), 32'h0);

        // reset mid-word discards the partial shift
        send_bits(16'h00F9, 8);
        link.sclk = 1'b0;
        link.data = 1'b0;
        rst_ni = 1'b0;
        clks(3);
        chk("mid_rst_digits", 32'(digits_o), 32'hAAAA);
        chk("mid_rst_err", 32'(err_o), 32'h0);
        rst_ni = 1'b1;
        clks(2);
        wv0 = wv_cnt;
        send_bits(16'hF901, 16);
        pulse_latch();
        chk("post_rst_wv", 32'(wv_cnt - wv0), 32'd1);
        chk("post_rst_digits", 32'(digits_o), 32'hAAA1);
        chk("post_rst_err", 32'(err_o), 32'h0);

        // latch with no clocks at all is a framing error
        wv0 = wv_cnt;
        pulse_latch();
        chk("bare_latch_err", 32'(err_o), 32'h1);
        chk("bare_latch_wv", 32'(wv_cnt - wv0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
